// File: rtl/decoder_arbiter.sv
// Round-robin arbiter sharing one inverted-mapping 3-to-8 decoder between
// eight requesters, with a bounded hold time and one dead cycle between grants.
module decoder_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic       en,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       tmo
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic       en_q, en_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] gnt_q, gnt_d;
    logic       busy_q, busy_d;
    logic       tmo_q, tmo_d;
    logic [2:0] last_q, last_d;
    logic [7:0] cnt_q, cnt_d;

    logic [3:0] pick;
    logic       found;
    logic [2:0] win;
    logic       owner_req;
    logic       hold_done;

    // First set bit strictly after last, wrapping; {found, index}.
    function automatic logic [3:0] rr_pick(
        input logic [7:0] r,
        input logic [2:0] last
    );
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = last + 3'(k);
            if (!res[3] && r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign pick      = rr_pick(req, last_q);
    assign found     = pick[3];
    assign win       = pick[2:0];
    assign owner_req = req[last_q];
    assign hold_done = (cnt_q == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (found) state_d = GRANT;
            end
            GRANT: begin
                if (!owner_req || hold_done) state_d = GAP;
            end
            GAP: begin
                state_d = found ? GRANT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        en_d   = 1'b0;
        sel_d  = sel_q;
        gnt_d  = 8'h00;
        tmo_d  = 1'b0;
        last_d = last_q;
        cnt_d  = cnt_q;
        busy_d = (state_d != IDLE);
        unique case (state_q)
            IDLE, GAP: begin
                if (found) begin
                    en_d   = 1'b1;
                    sel_d  = ~win;
                    gnt_d  = 8'b1 << win;
                    last_d = win;
                    cnt_d  = 8'h00;
                end
            end
            GRANT: begin
                if (state_d == GRANT) begin
                    en_d  = 1'b1;
                    gnt_d = gnt_q;
                    cnt_d = cnt_q + 8'h01;
                end else begin
                    // Released while still requesting means the hold expired.
                    tmo_d = owner_req;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            sel_q  <= 3'b000;
            gnt_q  <= 8'h00;
            busy_q <= 1'b0;
            tmo_q  <= 1'b0;
            last_q <= 3'd7;
            cnt_q  <= 8'h00;
        end else begin
            en_q   <= en_d;
            sel_q  <= sel_d;
            gnt_q  <= gnt_d;
            busy_q <= busy_d;
            tmo_q  <= tmo_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end

    assign en   = en_q;
    assign sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign tmo  = tmo_q;

    a_gnt_matches_decoder : assert property (
        @(posedge clk) disable iff (!rst_n)
        gnt_q == (en_q ? (8'b1 << (~sel_q)) : 8'h00)
    );

    a_gnt_onehot0 : assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(gnt_q)
    );

endmodule

// File: tb/tb_decoder_arbiter.sv
// Bench for decoder_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_decoder_arbiter;

    localparam int MH = 8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       en;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       tmo;

    int n_checks = 0;
    int n_err    = 0;

    decoder_arbiter #(.MAX_HOLD(MH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .en   (en),
        .sel  (sel),
        .gnt  (gnt),
        .busy (busy),
        .tmo  (tmo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp,
                     $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 granting, 2 dead cycle.
    int         m_state = 0;
    int         m_owner = 0;
    int         m_last  = 7;
    int         m_held  = 0;
    bit         m_tmo   = 1'b0;
    logic [2:0] m_sel   = 3'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_owner <= 0;
            m_last  <= 7;
            m_held  <= 0;
            m_tmo   <= 1'b0;
            m_sel   <= 3'd0;
        end else begin
            m_tmo <= 1'b0;
            if (m_state == 1) begin
                if (!req[m_owner]) begin
                    m_state <= 2;
                end else if (m_held >= MH) begin
                    m_state <= 2;
                    m_tmo   <= 1'b1;
                end else begin
                    m_held <= m_held + 1;
                end
            end else begin
                int w;
                w = -1;
                for (int k = 1; k <= 8; k++)
                    if (w < 0 && req[(m_last + k) % 8]) w = (m_last + k) % 8;
                if (w >= 0) begin
                    m_state <= 1;
                    m_owner <= w;
                    m_last  <= w;
                    m_held  <= 1;
                    m_sel   <= 3'(7 - w);
                end else begin
                    m_state <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_en", {7'b0, en}, {7'b0, m_state == 1});
        chk("m_gnt", gnt, (m_state == 1) ? 8'(1 << m_owner) : 8'h00);
        chk("m_sel", {5'b0, sel}, {5'b0, m_sel});
        chk("m_busy", {7'b0, busy}, {7'b0, m_state != 0});
        chk("m_tmo", {7'b0, tmo}, {7'b0, m_tmo});
        chk("inv", gnt, en ? 8'(1 << (7 - int'(sel))) : 8'h00);
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_en(output int w);
        int n;
        n = 0;
        w = -1;
        while (en !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        if (en !== 1'b1) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_en: no grant after %0d cycles", n);
        end else begin
            for (int i = 0; i < 8; i++) if (gnt[i]) w = i;
        end
    endtask

    initial begin
        int w;
        req   = 8'h00;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_en", {7'b0, en}, 8'h00);
        chk("rst_sel", {5'b0, sel}, 8'h00);
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_tmo", {7'b0, tmo}, 8'h00);

        // Single requester, three cycles.
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h01;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t1_en", {7'b0, en}, 8'h01);
            chk("t1_gnt", gnt, 8'h01);
            chk("t1_sel", {5'b0, sel}, 8'h07);
        end
        req = 8'h00;
        cyc();
        chk("t1_gap_en", {7'b0, en}, 8'h00);
        chk("t1_gap_busy", {7'b0, busy}, 8'h01);
        cyc();
        chk("t1_idle_busy", {7'b0, busy}, 8'h00);

        // Full rotation from reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            wait_en(w);
            chk("rr_order", 8'(w), 8'(i % 8));
            chk("rr_sel", {5'b0, sel}, 8'(7 - (i % 8)));
            cyc();
            chk("rr_hold2", {7'b0, en}, 8'h01);
            if (w >= 0) req[w] = 1'b0;
            cyc();
            chk("rr_gap", {6'b0, busy, en}, 8'h02);
            if (w >= 0) req[w] = 1'b1;
        end
        req = 8'h00;
        cyc();

        // Continuous hold on requester 4 hits the limit.
        req = 8'h10;
        cyc();
        for (int i = 0; i < MH; i++) begin
            chk("t3_gnt", gnt, 8'h10);
            chk("t3_sel", {5'b0, sel}, 8'h03);
            cyc();
        end
        chk("t3_gap_en", {7'b0, en}, 8'h00);
        chk("t3_tmo", {7'b0, tmo}, 8'h01);
        cyc();
        chk("t3_regrant", gnt, 8'h10);
        chk("t3_tmo_clr", {7'b0, tmo}, 8'h00);
        req = 8'h00;
        cyc();
        cyc();

        // Priority pointer and wrap-around.
        req = 8'h20;
        cyc();
        req = 8'h00;
        cyc();
        cyc();
        req = 8'h41;
        cyc();
        chk("t4_w6_gnt", gnt, 8'h40);
        chk("t4_w6_sel", {5'b0, sel}, 8'h01);
        req = 8'h00;
        cyc();
        cyc();
        req = 8'h21;
        cyc();
        chk("t4_wrap_gnt", gnt, 8'h01);
        chk("t4_wrap_sel", {5'b0, sel}, 8'h07);
        req = 8'h00;
        cyc();
        cyc();

        // Other requests ignored; drop coincides with expiry.
        req = 8'h04;
        cyc();
        for (int i = 1; i <= MH; i++) begin
            chk("t5_gnt", gnt, 8'h04);
            if (i == 3) req = 8'h0C;
            if (i == 5) req = 8'h04;
            if (i == MH) req = 8'h00;
            cyc();
        end
        chk("t5_gap", {6'b0, busy, en}, 8'h02);
        chk("t5_tmo", {7'b0, tmo}, 8'h00);
        cyc();

        // Asynchronous reset in the middle of a grant.
        req = 8'hFF;
        cyc();
        cyc();
        chk("t6_pre_en", {7'b0, en}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_en", {7'b0, en}, 8'h00);
        chk("t6_async_gnt", gnt, 8'h00);
        chk("t6_async_busy", {7'b0, busy}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("t6_restart_gnt", gnt, 8'h01);
        chk("t6_restart_sel", {5'b0, sel}, 8'h07);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
            if ($urandom_range(0, 299) == 0) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        req = 8'h00;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks,
                 n_err);
        $finish;
    end

endmodule

// File: doc/decoder_arbiter.md
Name: decoder_arbiter

Overview:
- Round-robin arbiter that shares the 3-to-8 output decoder between 8 requesters.
- Drives the decoder's en/sel so that exactly one requester's decoder line is active at a time.
- Decoder mapping is inverted: requester i owns decoder output d[i], and d[i] is selected when sel = 7 - i.
- Adds a hold-time limit so no requester can hold the decoder indefinitely.

Parameters:
- MAX_HOLD, 8: maximum consecutive GRANT cycles per grant; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request bits; req[i] = requester i wants the decoder, held high for the duration of use.
- en  output  1  decoder enable; high only in GRANT.
- sel  output  3  decoder select; equals 7 - winner index.
- gnt  output  8  one-hot grant; gnt[i] equals decoder d[i] for the current en/sel.
- busy  output  1  high while in GRANT or GAP.
- tmo  output  1  one-cycle pulse when a grant is ended by MAX_HOLD expiry.

Behaviour:
- All outputs are registered; none has a combinational path from req.
- Reset (rst_n low, async):
  - state = IDLE, en = 0, sel = 3'b000, gnt = 8'h00, busy = 0, tmo = 0.
  - last = 7, so requester 0 has top priority first; hold counter cnt = 0.
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the decoder.
  - GAP: exactly one dead cycle between grants.
- Arbitration (evaluated in IDLE and GAP):
  - Search req from index (last+1) mod 8 upward, wrapping 7 -> 0; first set bit wins.
  - If a winner is found, at the next edge: state = GRANT, en = 1, sel = 7 - w, gnt = 1<<w, busy = 1, last = w, cnt = 0.
  - If req == 0: IDLE stays IDLE; GAP goes to IDLE with all grant outputs low.
- Latency: req sampled at edge k -> en/gnt high after edge k, i.e. a one-cycle grant latency from IDLE.
- GRANT:
  - cnt increments each cycle (8-bit, never wraps because MAX_HOLD ≤ 255).
  - Release if req[last] is sampled low: state = GAP, en = 0, gnt = 0, tmo = 0.
  - Release if cnt == MAX_HOLD-1 with req[last] still high: state = GAP, en = 0, gnt = 0, tmo = 1 for that GAP cycle only.
  - Both conditions on the same edge: treated as normal release, tmo = 0.
  - Changes on other req bits during GRANT are ignored until the next arbitration.
- Grant length: never exceeds MAX_HOLD cycles. MAX_HOLD = 1 gives exactly a 1-cycle grant, then timeout unless req has dropped.
- GAP:
  - en = 0, gnt = 0, busy = 1, sel holds its last value.
  - Arbitration runs here, so back-to-back grants are separated by exactly 1 idle cycle.
- Fairness:
  - A timed-out requester that keeps requesting gets lowest priority at the next arbitration, since last = its index.
  - Any continuously requesting requester is granted within 7 intervening grants.
- Invariants:
  - gnt == (en ? 1 << (7-sel) : 0) at all times.
  - gnt is one-hot or zero.
- Reset mid-GRANT: outputs go to reset values immediately, without waiting for clk. Priority restarts at requester 0.

Test Plan:
- Reset, then req = 8'h01 held 3 cycles, then dropped -> en = 1, sel = 3'b111, gnt = 8'h01 for 3 cycles, then 1 GAP cycle (busy = 1, en = 0), then IDLE (busy = 0).
- From reset, req = 8'hFF, each requester holds 2 cycles then drops -> grant order 0,1,2,…,7,0 with sel = 7,6,5,…,0,7. Each grant is 2 cycles followed by 1 GAP cycle.
- req = 8'h10 held continuously, MAX_HOLD = 8 -> gnt = 8'h10, sel = 3'b011 for exactly 8 cycles. tmo = 1 in the GAP cycle, then a re-grant to requester 4 after GAP.
- last = 5, req = 8'h41 -> requester 6 wins (sel = 1). Then with last = 6 and req = 8'h21 -> requester 0 wins (sel = 7), checking wrap-around.
- Requester 2 in GRANT; req[3] rises and falls mid-grant -> no effect. req[2] and the timeout coincide on the final cycle -> GAP with tmo = 0.
- rst_n pulsed low mid-GRANT, asynchronously between edges -> en, gnt, busy drop immediately. Next arbitration with req = 8'hFF grants requester 0.
